// File: rtl/prio_encoder_hs.sv
// Handshaked priority encoder: one-entry output register behind a valid/ready pair.
// Define PRIO_ENCODER_RR_EN to replace fixed LSB-first priority with a round-robin pointer.
module prio_encoder_hs #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_multi,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic         none_q, none_d;
  logic         multi_q, multi_d;
  logic         accept;

  logic [W-1:0] win_idx;
  logic         win_none;
  logic         win_multi;

  assign win_none  = ~|in_req;
  // Clearing the lowest set bit leaves something behind iff two or more bits were set.
  assign win_multi = |(in_req & (in_req - {{(N-1){1'b0}}, 1'b1}));

`ifdef PRIO_ENCODER_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    int   pos;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= N) pos = pos - N;
      if (!found && in_req[pos]) begin
        found   = 1'b1;
        win_idx = W'(pos);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && !win_none)
      ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Scan downward so the lowest set bit is the last to write.
  always_comb begin
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_req[k]) win_idx = W'(k);
    end
  end
`endif

  assign in_ready = (state_q == EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    none_d  = none_q;
    multi_d = multi_q;
    if (accept) begin
      state_d = FULL;
      idx_d   = win_idx;
      none_d  = win_none;
      multi_d = win_multi;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      multi_q <= multi_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_idx   = idx_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Self-checking bench for prio_encoder_hs: directed spec scenarios plus a randomized
// handshake run scored against a behavioural model.
module tb_prio_encoder_hs;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_req = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_idx;
  logic         out_none;
  logic         out_multi;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_full;
  int m_idx;
  bit m_none;
  bit m_multi;
  int m_ptr;

  prio_encoder_hs #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_none(out_none), .out_multi(out_multi), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // first set bit scanning upward from ptr, wrapping around N
  function automatic int ref_idx(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_req = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    m_full = 0; m_idx = 0; m_none = 0; m_multi = 0; m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_idx !== '0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    if (out_none !== 1'b0) begin n_bad++; $display("FAIL reset_none: got %b want 0", out_none); end
    if (out_multi !== 1'b0) begin n_bad++; $display("FAIL reset_multi: got %b want 0", out_multi); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_onehot();
    do_reset();
    for (int j = 0; j < N; j++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_req = N'(1) << j;
      tick();
      n_cmp += 4;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL onehot_valid j=%0d: got %b want 1", j, out_valid); end
      if (out_idx !== W'(j)) begin n_bad++; $display("FAIL onehot_idx j=%0d: got %0d want %0d", j, out_idx, j); end
      if (out_none !== 1'b0) begin n_bad++; $display("FAIL onehot_none j=%0d: got %b want 0", j, out_none); end
      if (out_multi !== 1'b0) begin n_bad++; $display("FAIL onehot_multi j=%0d: got %b want 0", j, out_multi); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL onehot_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_multi_zero();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_req = 8'b1010_0100;
    tick();
    n_cmp += 3;
    if (out_idx !== 3'd2) begin n_bad++; $display("FAIL multi_idx: got %0d want 2", out_idx); end
    if (out_multi !== 1'b1) begin n_bad++; $display("FAIL multi_flag: got %b want 1", out_multi); end
    if (out_none !== 1'b0) begin n_bad++; $display("FAIL multi_none: got %b want 0", out_none); end
    in_req = '0;
    tick();
    n_cmp += 4;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_valid: got %b want 1", out_valid); end
    if (out_none !== 1'b1) begin n_bad++; $display("FAIL zero_none: got %b want 1", out_none); end
    if (out_idx !== 3'd0) begin n_bad++; $display("FAIL zero_idx: got %0d want 0", out_idx); end
    if (out_multi !== 1'b0) begin n_bad++; $display("FAIL zero_multi: got %b want 0", out_multi); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_req = 8'b0001_0000;
    tick();
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    if (out_idx !== 3'd4) begin n_bad++; $display("FAIL bp_first_idx: got %0d want 4", out_idx); end
    in_req = 8'b0000_0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready); end
      tick();
      n_cmp += 2;
      if (out_idx !== 3'd4) begin n_bad++; $display("FAIL bp_hold_idx c=%0d: got %0d want 4", c, out_idx); end
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c=%0d: got %b want 1", c, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_nobubble_valid: got %b want 1", out_valid); end
    if (out_idx !== 3'd0) begin n_bad++; $display("FAIL bp_second_idx: got %0d want 0", out_idx); end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

`ifdef PRIO_ENCODER_RR_EN
  task automatic test_rr();
    int exp_seq[4] = '{0, 1, 7, 0};
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_req = 8'b1000_0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_idx !== W'(exp_seq[i])) begin
        n_bad++; $display("FAIL rr_seq i=%0d: got %0d want %0d", i, out_idx, exp_seq[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    bit acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       in_req = '0;
        1:       in_req = N'(1) << $urandom_range(0, N - 1);
        default: in_req = N'($urandom);
      endcase
      #1;
      n_cmp += 2;
      if (in_ready !== (!m_full || out_ready)) begin
        n_bad++; $display("FAIL rand_in_ready c=%0d: got %b want %b", c, in_ready, (!m_full || out_ready));
      end
      if (out_valid !== m_full) begin
        n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, m_full);
      end
      if (m_full) begin
        n_cmp += 3;
        if (out_idx !== W'(m_idx)) begin n_bad++; $display("FAIL rand_idx c=%0d: got %0d want %0d", c, out_idx, m_idx); end
        if (out_none !== m_none) begin n_bad++; $display("FAIL rand_none c=%0d: got %b want %b", c, out_none, m_none); end
        if (out_multi !== m_multi) begin n_bad++; $display("FAIL rand_multi c=%0d: got %b want %b", c, out_multi, m_multi); end
      end
      acc = in_valid && (!m_full || out_ready);
      if (acc) begin
        m_full  = 1;
        m_none  = (in_req == '0);
        m_multi = ($countones(in_req) >= 2);
        m_idx   = m_none ? 0 : ref_idx(in_req, m_ptr);
`ifdef PRIO_ENCODER_RR_EN
        if (!m_none) m_ptr = (m_idx + 1) % N;
`endif
      end else if (out_ready) begin
        m_full = 0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_req = 8'b0001_0000;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_valid: got %b want 0", out_valid); end
    if (out_idx !== 3'd0) begin n_bad++; $display("FAIL rstmid_async_idx: got %0d want 0", out_idx); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_replay: got %b want 0", out_valid); end
    in_valid = 1'b1; out_ready = 1'b1; in_req = 8'b1000_0011;
    tick();
    n_cmp += 3;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_post_valid: got %b want 1", out_valid); end
    if (out_idx !== 3'd0) begin n_bad++; $display("FAIL rstmid_post_idx: got %0d want 0", out_idx); end
    if (out_multi !== 1'b1) begin n_bad++; $display("FAIL rstmid_post_multi: got %b want 1", out_multi); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multi_zero();
    test_backpressure();
`ifdef PRIO_ENCODER_RR_EN
    test_rr();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
